vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 15 +
 rtl/vram_arbiter_if.sv | 47 ++++
 rtl/vram_rd_pipe.sv | 30 +++
 rtl/vram_arbiter.sv | 105 ++++++++++
 tb/tb_vram_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared defaults and grant-source tags for the VRAM arbiter
package vram_pkg;

  localparam int VRAM_AW       = 15;
  localparam int VRAM_DW       = 8;
  localparam int VRAM_MAX_WAIT = 8;

  // Which requester owns the access issued in a given cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VID  = 2'd1,
    SRC_CPU  = 2'd2
  } src_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester and SRAM signal bundle for the VRAM arbiter
interface vram_arbiter_if #(
  parameter int AW = vram_pkg::VRAM_AW,
  parameter int DW = vram_pkg::VRAM_DW
);

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  vid_req, vid_addr,
    output vid_gnt, vid_rvalid, vid_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus the SRAM
  modport master (
    output vid_req, vid_addr,
    input  vid_gnt, vid_rvalid, vid_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vram_rd_pipe.sv
// rtl/vram_rd_pipe.sv - two-stage tag pipe that aligns rvalid with SRAM read data
module vram_rd_pipe
  import vram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  src_e rd_src,
  output logic vid_rvalid,
  output logic cpu_rvalid
);

  // tag_s1 matches the SRAM access cycle, tag_s2 the cycle its data is valid
  src_e tag_s1;
  src_e tag_s2;

  // Shift the read-owner tag along; reset drops any read still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_s1 <= SRC_NONE;
      tag_s2 <= SRC_NONE;
    end else begin
      tag_s1 <= rd_src;
      tag_s2 <= tag_s1;
    end
  end

  assign vid_rvalid = (tag_s2 == SRC_VID);
  assign cpu_rvalid = (tag_s2 == SRC_CPU);

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - video-priority single-port VRAM arbiter with CPU starvation guard
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW       = VRAM_AW,
  parameter int DW       = VRAM_DW,
  parameter int MAX_WAIT = VRAM_MAX_WAIT
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);

  localparam int            CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic          vid_win;
  logic          cpu_win;
  src_e          gnt_src;
  src_e          rd_src;

  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          vid_rvalid_w;
  logic          cpu_rvalid_w;

  // Pick this cycle's winner: video first unless the CPU has lost MAX_WAIT times in a row
  always_comb begin
    vid_win = 1'b0;
    cpu_win = 1'b0;
    gnt_src = SRC_NONE;
    if (!rst) begin
      cpu_win = bus.cpu_req && (!bus.vid_req || (wait_cnt == WAIT_SAT));
      vid_win = bus.vid_req && !cpu_win;
    end
    if (vid_win) begin
      gnt_src = SRC_VID;
    end else if (cpu_win) begin
      gnt_src = SRC_CPU;
    end
  end

  // Only reads get a response, so CPU writes enter the pipe as empty slots
  always_comb begin
    rd_src = gnt_src;
    if ((gnt_src == SRC_CPU) && bus.cpu_we) begin
      rd_src = SRC_NONE;
    end
  end

  // Count consecutive CPU losses, holding at the limit until the CPU gets through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!bus.cpu_req || cpu_win) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_SAT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Register the winning access onto the SRAM port; address/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= vid_win || cpu_win;
      mem_we_q <= cpu_win && bus.cpu_we;
      if (vid_win) begin
        mem_addr_q  <= bus.vid_addr;
        mem_wdata_q <= '0;
      end else if (cpu_win) begin
        mem_addr_q  <= bus.cpu_addr;
        mem_wdata_q <= bus.cpu_wdata;
      end
    end
  end

  vram_rd_pipe u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .rd_src     (rd_src),
    .vid_rvalid (vid_rvalid_w),
    .cpu_rvalid (cpu_rvalid_w)
  );

  assign bus.vid_gnt    = vid_win;
  assign bus.cpu_gnt    = cpu_win;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.vid_rvalid = vid_rvalid_w;
  assign bus.cpu_rvalid = cpu_rvalid_w;
  // Both requesters see the raw SRAM data; rvalid says whose it is
  assign bus.vid_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

  localparam int AW       = 15;
  localparam int DW       = 8;
  localparam int MAX_WAIT = 8;
  localparam int DEPTH    = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: unwritten locations return a fixed address pattern
  logic [DW-1:0] sram [DEPTH];
  logic          sram_wr [DEPTH];
  logic [DW-1:0] sram_q = '0;

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        sram[bus.mem_addr]    <= bus.mem_wdata;
        sram_wr[bus.mem_addr] <= 1'b1;
      end else begin
        sram_q <= (sram_wr[bus.mem_addr] === 1'b1) ? sram[bus.mem_addr] : pat(int'(bus.mem_addr));
      end
    end
  end

  assign bus.mem_rdata = sram_q;

  typedef struct {
    int            due;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mexp_t;

  typedef struct {
    int            due;
    logic          vv;
    logic          cv;
    logic [DW-1:0] data;
  } rexp_t;

  typedef struct {
    logic          r;
    logic          vreq;
    logic [AW-1:0] va;
    logic          creq;
    logic          cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          eg_v;
    logic          eg_c;
  } vec_t;

  mexp_t mq[$];
  rexp_t rvq[$];

  logic [DW-1:0] shadow [DEPTH];
  int            m_cnt  = 0;
  int            cyc    = 0;
  int            errors = 0;
  int            checks = 0;
  int            vcount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, check grants against the model, queue expectations, then check outputs
  task automatic step(input logic r, input logic vreq, input logic [AW-1:0] va,
                      input logic creq, input logic cwe, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd, output logic got_v, output logic got_c);
    logic  m_v, m_c;
    mexp_t me;
    rexp_t re;
    @(negedge clk);
    rst           = r;
    bus.vid_req   = vreq;
    bus.vid_addr  = va;
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    #1;
    m_c = !r && creq && (!vreq || m_cnt == MAX_WAIT);
    m_v = !r && vreq && !m_c;
    got_v = bus.vid_gnt;
    got_c = bus.cpu_gnt;
    chk("vid_gnt", 32'(bus.vid_gnt), 32'(m_v));
    chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(m_c));
    if (r) begin
      chk("rst_mem_en", 32'(bus.mem_en), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
      mq.delete();
      rvq.delete();
      re = '{due: cyc + 1, vv: 1'b0, cv: 1'b0, data: '0};
      rvq.push_back(re);
    end
    me = '{due: cyc + 1, en: m_v || m_c, we: m_c && cwe, addr: (m_v ? va : ca), wdata: cd};
    mq.push_back(me);
    re = '{due: cyc + 2, vv: m_v, cv: m_c && !cwe, data: (m_v ? shadow[va] : shadow[ca])};
    rvq.push_back(re);
    if (m_c && cwe) shadow[ca] = cd;
    if (r || !creq || m_c) m_cnt = 0;
    else if (m_cnt != MAX_WAIT) m_cnt++;

    @(posedge clk);
    cyc++;
    #1;
    chk("wait_cnt", 32'(dut.wait_cnt), 32'(m_cnt));
    if (bus.vid_rvalid) vcount++;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      me = mq.pop_front();
      chk("mem_en", 32'(bus.mem_en), 32'(me.en));
      chk("mem_we", 32'(bus.mem_we), 32'(me.we));
      if (me.en) chk("mem_addr", 32'(bus.mem_addr), 32'(me.addr));
      if (me.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(me.wdata));
    end
    if (rvq.size() > 0 && rvq[0].due == cyc) begin
      re = rvq.pop_front();
      chk("vid_rvalid", 32'(bus.vid_rvalid), 32'(re.vv));
      chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(re.cv));
      if (re.vv) chk("vid_rdata", 32'(bus.vid_rdata), 32'(re.data));
      if (re.cv) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(re.data));
    end
  endtask

  task automatic idle(input int n);
    logic gv, gc;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, gv, gc);
  endtask

  vec_t tbl[10];

  initial begin
    logic gv, gc;
    int   grant_at;
    int   vid_grants;
    bit   cpu_done;

    for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

    //        r     vreq  va        creq  cwe   ca        cd     eg_v  eg_c
    tbl[0] = '{1'b1, 1'b1, 15'h0005, 1'b1, 1'b0, 15'h0006, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 15'h0010, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 15'h1234, 8'hA5, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 15'h1234, 8'h00, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 15'h0020, 1'b1, 1'b0, 15'h0030, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 15'h0030, 8'h00, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 15'h7FFF, 1'b1, 1'b1, 15'h7FFE, 8'h3C, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 15'h7FFE, 8'h3C, 1'b0, 1'b1};

    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, gv, gc);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].vreq, tbl[i].va, tbl[i].creq, tbl[i].cwe,
           tbl[i].ca, tbl[i].cd, gv, gc);
      chk($sformatf("tbl%0d_vid_gnt", i), 32'(gv), 32'(tbl[i].eg_v));
      chk($sformatf("tbl%0d_cpu_gnt", i), 32'(gc), 32'(tbl[i].eg_c));
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 15'h7FFE, '0, gv, gc);
    idle(3);

    // Video hogs the port; the CPU must break through after exactly MAX_WAIT losses
    grant_at = -1;
    vid_grants = 0;
    cpu_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, AW'(16'h0100 + i), !cpu_done, 1'b0, 15'h0040, '0, gv, gc);
      if (gv) vid_grants++;
      if (gc && grant_at < 0) grant_at = i;
      if (gc) cpu_done = 1'b1;
    end
    chk("contention_cpu_cycle", 32'(grant_at), 32'(MAX_WAIT));
    chk("contention_vid_grants", 32'(vid_grants), 19);
    idle(3);

    // Back-to-back video stream
    vcount = 0;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, AW'(i), 1'b0, 1'b0, '0, '0, gv, gc);
    idle(3);
    chk("stream_rvalid_count", 32'(vcount), 16);

    // Reset lands the cycle after a read grant while the CPU is also waiting
    step(1'b0, 1'b1, 15'h0010, 1'b1, 1'b0, 15'h0050, '0, gv, gc);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, gv, gc);
    chk("reset_rvalid_vid", 32'(bus.vid_rvalid), 0);
    chk("reset_rvalid_cpu", 32'(bus.cpu_rvalid), 0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, gv, gc);
    idle(3);
    step(1'b0, 1'b1, 15'h0055, 1'b1, 1'b0, 15'h0066, '0, gv, gc);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
